// File: rtl/conf_chain.sv
// Configuration-chain endpoint.
// Assembles the serial configuration stream into a byte-addressed store that
// the fabric reads combinationally. It also runs an independent scan path
// that snapshots fabric state and shifts it out on tdo, LSB first.
module conf_chain #(
  parameter int NBYTES = 14795,
  parameter int AW     = 14,
  parameter int SBYTES = 149
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tdi,
  input  logic                  conf_el,
  input  logic                  conf_resetl,
  input  logic                  scanmode,
  input  logic [SBYTES*8-1:0]   scan_data,
  input  logic [AW-1:0]         cfg_addr,
  output logic [7:0]            cfg_data,
  output logic                  tdo,
  output logic                  conf_done,
  output logic                  conf_ovf
);

  localparam int            SW = SBYTES * 8;
  // wptr has one extra bit so it can sit at NBYTES when saturated
  localparam logic [AW:0]   NB = (AW+1)'(NBYTES);

  typedef enum logic [1:0] {IDLE, ARM, LOAD, DONE} state_t;

  state_t        state;
  logic [2:0]    bitcnt;
  logic [AW:0]   wptr;
  logic [7:0]    shreg;
  logic [7:0]    store [0:(1<<AW)-1];
  logic [SW-1:0] sreg;

  logic [7:0]    byte_in;
  logic          wr_en;

  assign byte_in = {shreg[6:0], tdi};
  // an 8th bit arriving in LOAD commits a byte, unless the frame is being restarted
  assign wr_en   = (state == LOAD) && conf_resetl && conf_el &&
                   (bitcnt == 3'd7) && (wptr < NB);

  // load FSM: frame restart beats everything, IDLE/DONE ignore the stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bitcnt    <= 3'd0;
      wptr      <= '0;
      shreg     <= 8'h00;
      conf_done <= 1'b0;
      conf_ovf  <= 1'b0;
    end else if (!conf_resetl) begin
      state     <= ARM;
      bitcnt    <= 3'd0;
      wptr      <= '0;
      conf_done <= 1'b0;
      conf_ovf  <= 1'b0;
    end else begin
      case (state)
        ARM: begin
          if (conf_el) begin
            state  <= LOAD;
            shreg  <= byte_in;
            bitcnt <= 3'd1;
          end
        end
        LOAD: begin
          if (conf_el) begin
            shreg  <= byte_in;
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              if (wptr < NB) wptr     <= wptr + (AW+1)'(1);
              else           conf_ovf <= 1'b1;
            end
          end else begin
            // any partial byte still in shreg is simply abandoned
            state     <= DONE;
            conf_done <= 1'b1;
          end
        end
        IDLE:    ;
        DONE:    ;
        default: state <= IDLE;
      endcase
    end
  end

  // store write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en) store[wptr[AW-1:0]] <= byte_in;
  end

  // fabric read port, out-of-range addresses read as zero
  assign cfg_data = ({1'b0, cfg_addr} < NB) ? store[cfg_addr] : 8'h00;

  // scan path: snapshot while idle, shift right with zero fill while scanning;
  // tdo tracks the next bit 0 so the first scan cycle already shows snapshot bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      tdo  <= 1'b0;
    end else if (!scanmode) begin
      sreg <= scan_data;
      tdo  <= scan_data[0];
    end else begin
      sreg <= {1'b0, sreg[SW-1:1]};
      tdo  <= sreg[1];
    end
  end

endmodule

// File: tb/tb_conf_chain.sv
// Bench for conf_chain: random frames and scans, scoreboard-checked against
// a byte/bit-level model of what the store, flags and tdo should show.
module tb_conf_chain;

  localparam int NB = 8;
  localparam int AW = 4;
  localparam int SB = 4;
  localparam int SW = SB * 8;

  localparam int K_DATA = 0;
  localparam int K_DONE = 1;
  localparam int K_OVF  = 2;
  localparam int K_TDO  = 3;

  logic          clk, rst_n, tdi, conf_el, conf_resetl, scanmode;
  logic [SW-1:0] scan_data;
  logic [AW-1:0] cfg_addr;
  logic [7:0]    cfg_data;
  logic          tdo, conf_done, conf_ovf;

  conf_chain #(.NBYTES(NB), .AW(AW), .SBYTES(SB)) dut (
    .clk(clk), .rst_n(rst_n), .tdi(tdi), .conf_el(conf_el),
    .conf_resetl(conf_resetl), .scanmode(scanmode), .scan_data(scan_data),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .tdo(tdo),
    .conf_done(conf_done), .conf_ovf(conf_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    int         kind;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // reference model state
  logic [7:0] ref_store [NB];
  bit         ref_valid [NB];
  bit         ref_ovf;
  int         fbits;
  logic [7:0] fbyte;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int kind, input logic [7:0] e, input string name);
    exp_t x;
    x.due  = cyc;
    x.kind = kind;
    x.exp  = e;
    x.name = name;
    sbq.push_back(x);
  endtask

  // monitor: samples mid-cycle and retires every expectation that is due
  initial begin
    exp_t       x;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        x = sbq.pop_front();
        case (x.kind)
          K_DATA:  act = cfg_data;
          K_DONE:  act = {7'b0, conf_done};
          K_OVF:   act = {7'b0, conf_ovf};
          default: act = {7'b0, tdo};
        endcase
        n_cmp++;
        if (act !== x.exp) begin
          n_err++;
          $display("FAIL %s: got %02h want %02h (cycle %0d)", x.name, act, x.exp, cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic start_frame();
    tick();
    conf_resetl = 1'b0;
    conf_el     = 1'($urandom_range(0, 1));
    tdi         = 1'($urandom_range(0, 1));
    tick();
    conf_resetl = 1'b1;
    conf_el     = 1'b0;
    fbits       = 0;
    ref_ovf     = 1'b0;
    expect_v(K_DONE, 8'd0, "arm_done");
    expect_v(K_OVF,  8'd0, "arm_ovf");
  endtask

  task automatic send_bit(input bit b);
    int idx;
    conf_el = 1'b1;
    tdi     = b;
    tick();
    conf_el = 1'b0;
    fbyte   = {fbyte[6:0], b};
    fbits++;
    if (fbits % 8 == 0) begin
      idx = fbits / 8 - 1;
      if (idx < NB) begin
        ref_store[idx] = fbyte;
        ref_valid[idx] = 1'b1;
        cfg_addr = AW'(idx);
        expect_v(K_DATA, fbyte, "byte_live");
      end else begin
        ref_ovf = 1'b1;
      end
      expect_v(K_OVF, {7'b0, ref_ovf}, "ovf_live");
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic end_frame();
    expect_v(K_DONE, 8'd0, "done_early");
    tick();
    expect_v(K_DONE, 8'd1, "done_rise");
    expect_v(K_OVF, {7'b0, ref_ovf}, "ovf_end");
  endtask

  task automatic check_store();
    for (int a = 0; a < (1 << AW); a++) begin
      if (a >= NB || ref_valid[a]) begin
        tick();
        cfg_addr = AW'(a);
        expect_v(K_DATA, (a < NB) ? ref_store[a] : 8'h00, "store_rd");
      end
    end
  endtask

  task automatic scan_run(input logic [SW-1:0] d);
    logic [SW-1:0] junk;
    tick();
    scanmode  = 1'b0;
    scan_data = d;
    tick();
    scanmode = 1'b1;
    expect_v(K_TDO, {7'b0, d[0]}, "tdo_first");
    for (int k = 1; k < SW + 3; k++) begin
      tick();
      for (int i = 0; i < SW; i++) junk[i] = 1'($urandom_range(0, 1));
      scan_data = junk;
      expect_v(K_TDO, (k < SW) ? {7'b0, d[k]} : 8'd0, "tdo_bit");
    end
    tick();
    scanmode = 1'b0;
  endtask

  initial begin
    logic [SW-1:0] d;
    int            nb;

    for (int i = 0; i < NB; i++) ref_valid[i] = 1'b0;
    rst_n = 1'b0; conf_resetl = 1'b1; conf_el = 1'b0; tdi = 1'b0;
    scanmode = 1'b0; scan_data = '0; cfg_addr = '0; fbits = 0; fbyte = 8'h00;
    ref_ovf = 1'b0;

    repeat (2) tick();
    expect_v(K_DONE, 8'd0, "reset_done");
    expect_v(K_OVF,  8'd0, "reset_ovf");
    expect_v(K_TDO,  8'd0, "reset_tdo");
    rst_n = 1'b1;

    // basic frame
    start_frame();
    send_byte(8'hA5); send_byte(8'h3C); send_byte(8'hFF);
    end_frame();
    check_store();

    // reset keeps the store; IDLE ignores the garbage stream
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(); conf_el = 1'b1; tdi = 1'b1;
      if (i % 8 == 7) expect_v(K_DONE, 8'd0, "idle_done");
    end
    tick(); conf_el = 1'b0;
    expect_v(K_DONE, 8'd0, "idle_done_end");
    check_store();
    start_frame();
    send_byte(8'($urandom));
    end_frame();
    check_store();

    // DONE ignores conf_el
    for (int i = 0; i < 10; i++) begin
      tick(); conf_el = 1'b1; tdi = 1'($urandom_range(0, 1));
      expect_v(K_DONE, 8'd1, "done_hold");
    end
    tick(); conf_el = 1'b0;
    check_store();

    // overflow: NB+1 full bytes then 3 stray bits
    start_frame();
    for (int i = 0; i < NB + 1; i++) send_byte(8'($urandom));
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    end_frame();
    check_store();

    // 12-bit frame writes only byte 0
    start_frame();
    for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)));
    end_frame();
    check_store();

    // abort after 13 bits, then a clean two-byte frame
    start_frame();
    for (int i = 0; i < 13; i++) send_bit(1'($urandom_range(0, 1)));
    start_frame();
    send_byte(8'h12); send_byte(8'h34);
    end_frame();
    check_store();

    // random frame lengths, including overflowing ones
    for (int f = 0; f < 6; f++) begin
      nb = $urandom_range(1, (NB + 2) * 8);
      start_frame();
      for (int i = 0; i < nb; i++) send_bit(1'($urandom_range(0, 1)));
      end_frame();
      check_store();
    end

    // scan readout: directed pattern then random snapshots
    d = '0;
    d[15:0] = 16'h81C3;
    d[SW-1:16] = (SW-16)'($urandom);
    scan_run(d);
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < SW; i++) d[i] = 1'($urandom_range(0, 1));
      scan_run(d);
    end

    // async reset in LOAD with overflow set and tdo high
    scanmode = 1'b0;
    scan_data = '1;
    start_frame();
    for (int i = 0; i < NB + 1; i++) send_byte(8'($urandom));
    send_bit(1'b1); send_bit(1'b0);
    expect_v(K_TDO, 8'd1, "pre_async_tdo");
    expect_v(K_OVF, 8'd1, "pre_async_ovf");
    tick(); #1;
    rst_n = 1'b0;
    #1;
    expect_v(K_OVF,  8'd0, "async_ovf");
    expect_v(K_DONE, 8'd0, "async_done_load");
    expect_v(K_TDO,  8'd0, "async_tdo_load");
    tick(); rst_n = 1'b1;

    // async reset mid-scan with conf_done high
    start_frame();
    send_byte(8'($urandom));
    end_frame();
    tick(); scanmode = 1'b0; scan_data = '1;
    tick(); scanmode = 1'b1;
    tick();
    expect_v(K_TDO,  8'd1, "pre_async_scan_tdo");
    expect_v(K_DONE, 8'd1, "pre_async_done");
    tick(); #1;
    rst_n = 1'b0;
    #1;
    expect_v(K_TDO,  8'd0, "async_tdo_scan");
    expect_v(K_DONE, 8'd0, "async_done_scan");
    tick(); rst_n = 1'b1; scanmode = 1'b0;
    check_store();

    // drain the scoreboard with a bound
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conf_chain.md
Name: conf_chain

Overview:
- Configuration-chain endpoint that sits directly downstream of the configuration memory/loader.
- It consumes the serial configuration stream (tdi, conf_el, conf_resetl) and assembles it into a byte-addressed configuration store that the fabric reads.
- It also serves the reverse scan path: it snapshots fabric state and returns it on tdo, one bit per clock, while scanmode is high.

Parameters:
- NBYTES, 14795, configuration store capacity in bytes.
- AW, 14, width of the store address (2^AW >= NBYTES).
- SBYTES, 149, scan snapshot length in bytes (scan vector is SBYTES*8 bits).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tdi  input  1  serial config data, MSB of each byte first.
- conf_el  input  1  config shift enable; high = a bit is valid on tdi this cycle.
- conf_resetl  input  1  active-low frame start; a low cycle arms a new load.
- scanmode  input  1  high = scan readout in progress.
- scan_data  input  SBYTES*8  fabric state to be scanned out; bit 0 goes first.
- cfg_addr  input  AW  fabric read address into the store.
- cfg_data  output  8  combinational read data, store[cfg_addr]; 0 if cfg_addr >= NBYTES.
- tdo  output  1  scan serial out, registered.
- conf_done  output  1  high when a load has completed and the store is valid.
- conf_ovf  output  1  sticky; more than NBYTES full bytes were received in the current frame.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, bitcnt=0, wptr=0, shreg=0.
  - conf_done=0, conf_ovf=0, tdo=0, scan shift register cleared.
  - Store contents are not reset.
- FSM states: IDLE, ARM, LOAD, DONE.
  - Any state, conf_resetl low: next state=ARM, bitcnt=0, wptr=0, conf_done=0, conf_ovf=0. This takes priority over every other event, including mid-LOAD, which aborts that load.
  - IDLE: conf_el is ignored (the loader holds conf_el high while idle; those bits are garbage).
  - ARM: on a conf_el high cycle, go to LOAD and capture that bit as the first bit.
  - LOAD, each conf_el high cycle: shreg <= {shreg[6:0], tdi}; bitcnt++.
  - LOAD, completing bit (bitcnt==7):
    - store[wptr] <= {shreg[6:0], tdi}; wptr++; bitcnt wraps to 0.
    - If wptr >= NBYTES, the write is suppressed, wptr saturates, and conf_ovf is set.
  - LOAD, first cycle with conf_el low: go to DONE; conf_done=1 from the next cycle.
    - A partial byte (bitcnt != 0) is discarded.
    - conf_done does not depend on wptr; the loader decides frame length.
  - DONE: hold. conf_el high in DONE is ignored. Only conf_resetl low leaves DONE.
- Latency:
  - A byte is readable on cfg_data the cycle after its 8th bit is sampled.
  - conf_done rises 1 cycle after the first conf_el-low cycle in LOAD.
- Scan path (independent of the FSM):
  - While scanmode is low, the scan shift register loads scan_data every cycle.
  - While scanmode is high, it shifts right by 1 per cycle, with 0 shifted into the MSB.
  - tdo = shift register bit 0, registered. On the first cycle scanmode is high, tdo = bit 0 of scan_data as sampled on the last scanmode-low edge.
  - Bit k of the snapshot appears on tdo on scan cycle k. This matches the consumer assembling each byte LSB-first at one bit per clock.
  - After SBYTES*8 cycles tdo=0.
  - Dropping and re-raising scanmode re-snapshots.
- Simultaneous events:
  - conf_resetl low with conf_el high: the conf_el bit is dropped.
  - Scan and load activity are orthogonal and may overlap without interaction.
- cfg_data is purely combinational. A read and a write to the same address in the same cycle return the old byte.

Test Plan:
- Reset then a frame:
  - Stimulus: pulse conf_resetl low 1 cycle, then conf_el high for 24 cycles with tdi = bytes 0xA5, 0x3C, 0xFF MSB-first, then conf_el low.
  - Required: store[0..2] = A5,3C,FF; conf_done=1 exactly 1 cycle after conf_el falls; conf_ovf=0.
- Garbage rejection:
  - Stimulus: conf_el high with tdi=1 for 40 cycles before any conf_resetl pulse.
  - Required: state stays IDLE, conf_done=0, store unchanged; a subsequent frame loads byte 0 correctly.
- Partial byte and overflow:
  - Stimulus 1: with NBYTES=4, send 5 full bytes plus 3 bits.
  - Required 1: store[0..3] written; conf_ovf=1; 5th byte and partial bits discarded; conf_done=1.
  - Stimulus 2: send 12 bits only.
  - Required 2: only store[0] written.
- Abort mid-load:
  - Stimulus: after 13 bits of a frame, conf_resetl low for 1 cycle, then a clean 16-bit frame 0x12,0x34.
  - Required: conf_done=0 during the abort; store[0]=0x12, store[1]=0x34.
- Scan readout:
  - Stimulus: scan_data = 0x…_81_C3 (byte0=0xC3, byte1=0x81); raise scanmode for 16 cycles while changing scan_data mid-scan.
  - Required: tdo sequence 1,1,0,0,0,0,1,1 then 1,0,0,0,0,0,0,1; mid-scan changes have no effect; after SBYTES*8 cycles tdo=0.
- Async reset mid-operation:
  - Stimulus: assert rst_n low asynchronously during LOAD and during scan.
  - Required: conf_done, conf_ovf and tdo go 0 immediately, without waiting for a clock edge.
